// File: rtl/rca_accumulator_if.sv
// Operand/command bundle between the control logic and rca_accumulator.
// master drives commands and operands; slave (the accumulator) returns status and result.
interface rca_accumulator_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) ();
  logic              start;
  logic [CNT_W-1:0]  len;
  logic              cin_init;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [DATA_W-1:0] acc;
  logic              carry_flag;
  logic              busy;
  logic              done;

  modport master (
    output start, len, cin_init, in_valid, in_data,
    input  in_ready, acc, carry_flag, busy, done
  );

  modport slave (
    input  start, len, cin_init, in_valid, in_data,
    output in_ready, acc, carry_flag, busy, done
  );
endinterface

// File: rtl/rca_accumulator.sv
// rca_accumulator: sums len operands through one 8-bit ripple-carry adder; RCA_ACC_SAT_EN clamps acc to 8'hFF on carry-out.
// Result and done arrive one clock after the last beat; in_ready is state-decoded, so in_valid may stall a run indefinitely.
module ripple_carry_adder_dataflow (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] S,
  output logic       Cout
);
  logic [8:0] w_c;

  assign w_c[0] = Cin;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign S[i]     = A[i] ^ B[i] ^ w_c[i];
    assign w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
  end

  assign Cout = w_c[8];
endmodule

module rca_accumulator #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic clk,
  input  logic rst_n,
  rca_accumulator_if.slave bus
);
  if (DATA_W != 8) begin : g_width_check
    $error("rca_accumulator: DATA_W must be 8 to match the adder instance");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DATA_W-1:0]  r_acc;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_first;
  logic               r_cin;

  logic               w_in_ready;
  logic               w_busy;
  logic               w_done;
  logic               w_beat;
  logic               w_cin;
  logic [DATA_W-1:0]  w_sum;
  logic               w_cout;
  logic [DATA_W-1:0]  w_acc_nxt;

  ripple_carry_adder_dataflow u_adder (
    .A    (r_acc),
    .B    (bus.in_data),
    .Cin  (w_cin),
    .S    (w_sum),
    .Cout (w_cout)
  );

`ifdef RCA_ACC_SAT_EN
  // Once clamped, acc=FF plus any nonzero operand carries out again, so it stays at FF.
  assign w_acc_nxt = w_cout ? {DATA_W{1'b1}} : w_sum;
`else
  assign w_acc_nxt = w_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_beat      = 1'b0;
    w_cin       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt = (bus.len != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b1;
        w_beat     = bus.in_valid;
        w_cin      = r_first & r_cin;
        if (w_beat && (r_cnt == CNT_W'(1))) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_first <= 1'b0;
      r_cin   <= 1'b0;
    end else if ((r_state == ST_IDLE) && bus.start) begin
      r_acc   <= '0;
      r_carry <= 1'b0;
      if (bus.len != '0) begin
        r_cnt   <= bus.len;
        r_first <= 1'b1;
        r_cin   <= bus.cin_init;
      end
    end else if (w_beat) begin
      r_acc   <= w_acc_nxt;
      r_carry <= r_carry | w_cout;
      r_cnt   <= r_cnt - CNT_W'(1);
      r_first <= 1'b0;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
  assign bus.acc        = r_acc;
  assign bus.carry_flag = r_carry;
endmodule

// File: tb/tb_rca_accumulator.sv
// Self-checking bench for rca_accumulator: directed scenarios plus randomized runs
// compared against an integer-arithmetic reference model.
module tb_rca_accumulator;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] q_data[$];
  logic [7:0] res_acc;
  logic       res_cf;
  logic       res_busy_done;
  int         res_beats;
  int         res_done_cnt;
  int         res_lat;
  int         res_hold_bad;
  bit         res_tmo;
  logic [7:0] exp_acc;
  logic       exp_cf;

`ifdef RCA_ACC_SAT_EN
  localparam logic [7:0] WRAP_EXP = 8'hFF;
`else
  localparam logic [7:0] WRAP_EXP = 8'h00;
`endif

  rca_accumulator_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  rca_accumulator #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: running integer sum, carry-in on the first operand only, overflow when the sum exceeds 255.
  task automatic model(input bit ci);
    int a;
    int s;
    a = 0;
    exp_cf = 1'b0;
    foreach (q_data[i]) begin
      s = a + int'(q_data[i]) + ((i == 0) ? int'(ci) : 0);
      if (s > 255) exp_cf = 1'b1;
`ifdef RCA_ACC_SAT_EN
      a = (s > 255) ? 255 : s;
`else
      a = s % 256;
`endif
    end
    exp_acc = 8'(a);
  endtask

  // Issues one command for q_data and feeds the beats; records what the DUT reported.
  // stray_cyc >= 0 pulses an extra start at that cycle; -2 pulses it in the done cycle.
  task automatic run_cmd(input bit ci, input int gap, input int stray_cyc, input int stray_len);
    int         n;
    int         k;
    int         since;
    int         gl;
    bit         ready;
    logic [7:0] acc_prev;
    n = q_data.size();
    k = 0;
    since = -1;
    res_done_cnt = 0;
    res_tmo = 1'b1;
    res_hold_bad = 0;
    res_acc = 8'h00;
    res_cf = 1'b0;
    res_lat = -2;
    res_beats = -1;
    res_busy_done = 1'b1;
    bus.start = 1'b1;
    bus.len = CNT_W'(n);
    bus.cin_init = ci;
    bus.in_valid = 1'b0;
    step();
    bus.start = 1'b0;
    gl = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
    for (int c = 0; c < 400; c++) begin
      if (bus.done) begin
        res_done_cnt++;
        if (res_done_cnt == 1) begin
          res_acc = bus.acc;
          res_cf = bus.carry_flag;
          res_beats = k;
          res_lat = since;
          res_busy_done = bus.busy | bus.in_ready;
        end
      end
      if (res_done_cnt > 0 && !bus.done) begin
        res_tmo = 1'b0;
        break;
      end
      ready = bus.in_ready;
      bus.in_valid = (k < n) && (gl <= 0);
      bus.in_data = bus.in_valid ? q_data[k] : 8'($urandom);
      if (c == stray_cyc || (stray_cyc == -2 && bus.done)) begin
        bus.start = 1'b1;
        bus.len = CNT_W'(stray_len);
        bus.cin_init = 1'($urandom);
      end
      acc_prev = bus.acc;
      step();
      bus.start = 1'b0;
      if (bus.in_valid && ready) begin
        k++;
        since = 0;
        gl = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      end else begin
        if (since >= 0) since++;
        if (gl > 0 && ready) gl--;
        if (ready && bus.acc !== acc_prev) res_hold_bad++;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b1;
    bus.len = 4'd3;
    bus.cin_init = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h55;
    rst_n = 1'b0;
    step();
    step();
    checks++; if (bus.acc !== 8'h00) begin errors++; $display("FAIL reset_acc got %h want 00", bus.acc); end
    checks++; if (bus.carry_flag !== 1'b0) begin errors++; $display("FAIL reset_carry got %b want 0", bus.carry_flag); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_basic();
    q_data = '{8'h01, 8'h01};
    run_cmd(1'b0, 0, -1, 0);
    checks++; if (res_tmo !== 1'b0) begin errors++; $display("FAIL basic_timeout no done pulse"); end
    checks++; if (res_acc !== 8'h02) begin errors++; $display("FAIL basic_acc got %h want 02", res_acc); end
    checks++; if (res_cf !== 1'b0) begin errors++; $display("FAIL basic_carry got %b want 0", res_cf); end
    checks++; if (res_lat !== 0) begin errors++; $display("FAIL basic_latency got %0d want 0", res_lat); end
    checks++; if (res_beats !== 2) begin errors++; $display("FAIL basic_beats got %0d want 2", res_beats); end
    checks++; if (res_done_cnt !== 1) begin errors++; $display("FAIL basic_done_width got %0d want 1", res_done_cnt); end
    checks++; if (res_busy_done !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b want 0", res_busy_done); end
  endtask

  task automatic test_cin_first_beat();
    q_data = '{8'h03};
    run_cmd(1'b1, 0, -1, 0);
    checks++; if (res_acc !== 8'h04) begin errors++; $display("FAIL cin_len1_acc got %h want 04", res_acc); end
    q_data = '{8'h03, 8'h03};
    run_cmd(1'b1, 0, -1, 0);
    checks++; if (res_acc !== 8'h07) begin errors++; $display("FAIL cin_len2_acc got %h want 07", res_acc); end
    checks++; if (res_cf !== 1'b0) begin errors++; $display("FAIL cin_len2_carry got %b want 0", res_cf); end
  endtask

  task automatic test_wrap();
    q_data = '{8'hFF, 8'h01};
    run_cmd(1'b0, 0, -1, 0);
    checks++; if (res_acc !== WRAP_EXP) begin errors++; $display("FAIL wrap_acc got %h want %h", res_acc, WRAP_EXP); end
    checks++; if (res_cf !== 1'b1) begin errors++; $display("FAIL wrap_carry got %b want 1", res_cf); end
  endtask

  task automatic test_gaps();
    q_data = '{8'h19, 8'h31, 8'h03};
    run_cmd(1'b0, 2, -1, 0);
    checks++; if (res_acc !== 8'h4D) begin errors++; $display("FAIL gaps_acc got %h want 4d", res_acc); end
    checks++; if (res_beats !== 3) begin errors++; $display("FAIL gaps_beats_before_done got %0d want 3", res_beats); end
    checks++; if (res_hold_bad !== 0) begin errors++; $display("FAIL gaps_hold acc changed %0d times want 0", res_hold_bad); end
    checks++; if (res_lat !== 0) begin errors++; $display("FAIL gaps_latency got %0d want 0", res_lat); end
  endtask

  task automatic test_reset_mid_run();
    int dones;
    bus.start = 1'b1;
    bus.len = 4'd4;
    bus.cin_init = 1'b0;
    step();
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h10;
    step();
    bus.in_valid = 1'b0;
    checks++; if (bus.acc !== 8'h10) begin errors++; $display("FAIL midrst_partial got %h want 10", bus.acc); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.acc !== 8'h00) begin errors++; $display("FAIL midrst_acc got %h want 00", bus.acc); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got %b want 0", bus.in_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
    step();
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.done) dones++;
      step();
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL midrst_no_done got %0d pulses want 0", dones); end
    q_data = '{8'h81};
    run_cmd(1'b0, 0, -1, 0);
    checks++; if (res_acc !== 8'h81) begin errors++; $display("FAIL midrst_rerun_acc got %h want 81", res_acc); end
    checks++; if (res_done_cnt !== 1) begin errors++; $display("FAIL midrst_rerun_done got %0d want 1", res_done_cnt); end
  endtask

  task automatic test_len_zero_and_ignored_start();
    logic ci;
    q_data.delete();
    run_cmd(1'b0, 0, -1, 0);
    checks++; if (res_done_cnt !== 1) begin errors++; $display("FAIL len0_done got %0d want 1", res_done_cnt); end
    checks++; if (res_acc !== 8'h00) begin errors++; $display("FAIL len0_acc got %h want 00", res_acc); end
    checks++; if (res_lat !== -1) begin errors++; $display("FAIL len0_latency got %0d want -1", res_lat); end
    q_data = '{8'($urandom), 8'($urandom)};
    model(1'b0);
    run_cmd(1'b0, 0, 1, 5);
    checks++; if (res_tmo !== 1'b0) begin errors++; $display("FAIL restart_timeout no done pulse"); end
    checks++; if (res_beats !== 2) begin errors++; $display("FAIL restart_beats got %0d want 2", res_beats); end
    checks++; if (res_acc !== exp_acc) begin errors++; $display("FAIL restart_acc got %h want %h", res_acc, exp_acc); end
    ci = 1'($urandom);
    q_data = '{8'($urandom)};
    model(ci);
    run_cmd(ci, 0, -2, 3);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL start_at_done_busy got %b want 0", bus.busy); end
    checks++; if (bus.acc !== exp_acc) begin errors++; $display("FAIL start_at_done_acc got %h want %h", bus.acc, exp_acc); end
    step();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL start_at_done_ready got %b want 0", bus.in_ready); end
  endtask

  task automatic test_random();
    int  n;
    bit  ci;
    for (int t = 0; t < 25; t++) begin
      n = int'($urandom_range(1, 15));
      ci = 1'($urandom);
      q_data.delete();
      for (int i = 0; i < n; i++) q_data.push_back(8'($urandom));
      model(ci);
      run_cmd(ci, -1, -1, 0);
      checks++; if (res_acc !== exp_acc) begin errors++; $display("FAIL rand%0d_acc got %h want %h", t, res_acc, exp_acc); end
      checks++; if (res_cf !== exp_cf) begin errors++; $display("FAIL rand%0d_carry got %b want %b", t, res_cf, exp_cf); end
      checks++; if (res_beats !== n) begin errors++; $display("FAIL rand%0d_beats got %0d want %0d", t, res_beats, n); end
      checks++; if (res_done_cnt !== 1) begin errors++; $display("FAIL rand%0d_done got %0d want 1", t, res_done_cnt); end
      checks++; if (res_hold_bad !== 0) begin errors++; $display("FAIL rand%0d_hold got %0d want 0", t, res_hold_bad); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cin_first_beat();
    test_wrap();
    test_gaps();
    test_reset_mid_run();
    test_len_zero_and_ignored_start();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
